// File: rtl/vga_layer_mixer.sv
// VGA timing generator and N-layer priority compositor with per-layer blinking.
// Pixel outputs lag the issued coordinate by LAT+1 pix_en ticks; no backpressure, free-running.
module vga_layer_mixer #(
  parameter int CLK_DIV      = 4,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int N_LAYER      = 4,
  parameter int LAT          = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   pix_en,
  output logic [9:0]             h_cnt,
  output logic [9:0]             v_cnt,
  input  logic [N_LAYER-1:0]     layer_valid,
  input  logic [12*N_LAYER-1:0]  layer_pixel,
  input  logic [N_LAYER-1:0]     layer_blink,
  input  logic [11:0]            bg_color,
  output logic                   hsync,
  output logic                   vsync,
  output logic [3:0]             vgaRed,
  output logic [3:0]             vgaGreen,
  output logic [3:0]             vgaBlue,
  output logic                   frame_start,
  output logic                   blink_phase
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int BF_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [BF_W-1:0]  BF_LAST  = BF_W'(BLINK_FRAMES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
    $error("vga_layer_mixer: H_TOTAL and V_TOTAL must fit 10-bit counters");
  end

  logic [DIV_W-1:0] div_q;
  logic [9:0]       h_q;
  logic [9:0]       v_q;
  logic             h_wrap;
  logic             v_wrap;

  assign pix_en      = (div_q == DIV_LAST);
  assign h_wrap      = (h_q == H_LAST);
  assign v_wrap      = (v_q == V_LAST);
  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign frame_start = pix_en && (h_q == 10'd0) && (v_q == 10'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= pix_en ? '0 : div_q + 1'b1;
      if (pix_en) begin
        h_q <= h_wrap ? 10'd0 : h_q + 10'd1;
        if (h_wrap) begin
          v_q <= v_wrap ? 10'd0 : v_q + 10'd1;
        end
      end
    end
  end

  // {hs, vs, valid} for the coordinate currently issued
  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic [2:0]  raw;
  logic [2:0]  tap;

  assign h_ext  = {1'b0, h_q};
  assign v_ext  = {1'b0, v_q};
  assign raw[2] = !((h_ext >= HS_BEG) && (h_ext < HS_END));
  assign raw[1] = !((v_ext >= VS_BEG) && (v_ext < VS_END));
  assign raw[0] = (h_ext < H_ACT) && (v_ext < V_ACT);

  if (LAT == 0) begin : g_no_dly
    assign tap = raw;
  end else begin : g_dly
    logic [2:0] dly_q [LAT];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < LAT; i++) dly_q[i] <= 3'b110;
      end else if (pix_en) begin
        dly_q[0] <= raw;
        for (int i = 1; i < LAT; i++) dly_q[i] <= dly_q[i-1];
      end
    end
    assign tap = dly_q[LAT-1];
  end

  // The first frame_start after reset opens frame 0; later ones each close a frame.
  logic [BF_W-1:0] bcnt_q, bcnt_d;
  logic            started_q, started_d;
  logic            blink_q, blink_d;

  always_comb begin
    bcnt_d    = bcnt_q;
    started_d = started_q;
    blink_d   = blink_q;
    if (frame_start) begin
      if (!started_q) begin
        started_d = 1'b1;
      end else if (bcnt_q == BF_LAST) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q    <= '0;
      started_q <= 1'b0;
      blink_q   <= 1'b0;
    end else begin
      bcnt_q    <= bcnt_d;
      started_q <= started_d;
      blink_q   <= blink_d;
    end
  end

  assign blink_phase = blink_q;

  // Mixing uses the phase that takes effect on this tick, so a toggle never splits a pixel.
  logic [N_LAYER-1:0] eff;
  logic [11:0]        pix_sel;
  logic               hit;

  assign eff = layer_valid & ~(layer_blink & {N_LAYER{blink_d}});

  always_comb begin
    pix_sel = bg_color;
    hit     = 1'b0;
    for (int i = 0; i < N_LAYER; i++) begin
      if (eff[i] && !hit) begin
        pix_sel = layer_pixel[12*i +: 12];
        hit     = 1'b1;
      end
    end
  end

  logic [11:0] rgb_q;
  logic        hs_q;
  logic        vs_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q <= 12'h000;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (pix_en) begin
      rgb_q <= tap[0] ? pix_sel : 12'h000;
      hs_q  <= tap[2];
      vs_q  <= tap[1];
    end
  end

  assign hsync    = hs_q;
  assign vsync    = vs_q;
  assign vgaRed   = rgb_q[11:8];
  assign vgaGreen = rgb_q[7:4];
  assign vgaBlue  = rgb_q[3:0];

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed bench for vga_layer_mixer on a reduced raster: coordinate-driven layer sources
// with hand-picked checkpoints plus per-tick stream accounting.
module tb_vga_layer_mixer;
  localparam int CLK_DIV = 4;
  localparam int HA = 120, HF = 8, HS = 16, HB = 8;
  localparam int VA = 6,   VF = 1, VS = 2,  VB = 1;
  localparam int NL = 4, LAT = 2, BF = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int M_PRIO = 0, M_NONE = 1, M_ALIGN = 2, M_BLINK = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              pix_en;
  logic [9:0]        h_cnt, v_cnt;
  logic [NL-1:0]     layer_valid;
  logic [12*NL-1:0]  layer_pixel;
  logic [NL-1:0]     layer_blink;
  logic [11:0]       bg_color;
  logic              hsync, vsync;
  logic [3:0]        vgaRed, vgaGreen, vgaBlue;
  logic              frame_start, blink_phase;
  logic [11:0]       rgb;

  assign rgb = {vgaRed, vgaGreen, vgaBlue};

  always #5 clk = ~clk;

  vga_layer_mixer #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .N_LAYER(NL), .LAT(LAT), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .layer_valid(layer_valid), .layer_pixel(layer_pixel), .layer_blink(layer_blink),
    .bg_color(bg_color), .hsync(hsync), .vsync(vsync),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
    .frame_start(frame_start), .blink_phase(blink_phase)
  );

  int n_checks = 0;
  int n_err    = 0;

  int k, mode;
  int err_rgb, err_sync, err_coord, err_fs, err_period, err_hold, err_blink;
  int n_hs_low, n_vs_low, n_fs, n_white, white_col;
  logic [9:0]  last_h, last_v;
  logic        last_fs;
  logic [11:0] p_rgb;
  logic        p_hs, p_vs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int kt(input int f, input int h, input int v);
    return f * FT + v * HT + h + LAT;
  endfunction

  // One pixel tick: find the strobe, drive layers for the tap coordinate, sample after the edge.
  task automatic tick();
    int gap, exp_h, exp_v, c, hh, vv, e_ph;
    logic [NL-1:0]    d_lv, d_lb;
    logic [12*NL-1:0] d_lp;
    logic [11:0]      d_bg, e_rgb;
    logic             e_hs, e_vs;
    gap = 1;
    @(negedge clk);
    while (pix_en !== 1'b1 && gap < 4 * CLK_DIV) begin
      if ({rgb, hsync, vsync} !== {p_rgb, p_hs, p_vs}) err_hold++;
      @(negedge clk);
      gap++;
    end
    if (pix_en !== 1'b1) begin
      check_eq("pix_en_timeout", 32'(gap), 32'(CLK_DIV));
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $fatal(1, "pixel strobe lost");
    end
    if (k > 0 && gap != CLK_DIV) err_period++;
    exp_h  = k % HT;
    exp_v  = (k / HT) % VT;
    last_h = h_cnt;
    last_v = v_cnt;
    last_fs = frame_start;
    if (h_cnt !== 10'(exp_h) || v_cnt !== 10'(exp_v)) err_coord++;
    if (frame_start !== (exp_h == 0 && exp_v == 0)) err_fs++;
    if (frame_start === 1'b1) n_fs++;

    c  = k - LAT;
    hh = (c >= 0) ? c % HT : 0;
    vv = (c >= 0) ? (c / HT) % VT : 0;
    d_lb = '0;
    d_lp = {12'h123, 12'h0F0, 12'hF00, 12'h555};
    d_bg = 12'h68A;
    d_lv = '0;
    case (mode)
      M_PRIO: d_lv = 4'b0110;
      M_NONE: d_lv = 4'b0000;
      M_ALIGN: begin
        d_lv = (hh == 100) ? 4'b0001 : 4'b0000;
        d_lp[11:0] = 12'hFFF;
        d_bg = 12'h000;
      end
      default: begin
        d_lv = 4'b0011;
        d_lb = 4'b0001;
        d_lp[11:0]  = 12'h00F;
        d_lp[23:12] = 12'hF00;
      end
    endcase
    layer_valid = d_lv;
    layer_pixel = d_lp;
    layer_blink = d_lb;
    bg_color    = d_bg;

    @(posedge clk);
    #1;
    e_ph = ((k / FT) / BF) % 2;
    if (c < 0) begin
      e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1;
    end else begin
      e_hs = !(hh >= HA + HF && hh < HA + HF + HS);
      e_vs = !(vv >= VA + VF && vv < VA + VF + VS);
      e_rgb = 12'h000;
      if (hh < HA && vv < VA) begin
        e_rgb = d_bg;
        for (int i = NL - 1; i >= 0; i--)
          if (d_lv[i] && !(d_lb[i] && e_ph == 1)) e_rgb = d_lp[12*i +: 12];
      end
    end
    if (rgb !== e_rgb) err_rgb++;
    if (hsync !== e_hs || vsync !== e_vs) err_sync++;
    if (blink_phase !== e_ph[0]) err_blink++;
    if (hsync === 1'b0) n_hs_low++;
    if (vsync === 1'b0) n_vs_low++;
    if (rgb === 12'hFFF) begin n_white++; white_col = hh; end
    p_rgb = rgb; p_hs = hsync; p_vs = vsync;

    layer_valid = 4'($urandom);
    layer_pixel = 48'({$urandom, $urandom});
    layer_blink = 4'($urandom);
    bg_color    = 12'($urandom);
    k++;
  endtask

  task automatic run_until(input int target);
    while (k <= target) tick();
  endtask

  task automatic release_reset();
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    k = 0;
    p_rgb = 12'h000; p_hs = 1'b1; p_vs = 1'b1;
    while (!seen && n < 4 * CLK_DIV) begin
      @(posedge clk);
      #1;
      n++;
      seen = (pix_en === 1'b1);
    end
    check_eq("first_pix_en_clk", 32'(n + 1), 32'd4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    layer_valid = '0; layer_pixel = '0; layer_blink = '0; bg_color = '0;
    mode = M_PRIO;
    err_rgb = 0; err_sync = 0; err_coord = 0; err_fs = 0;
    err_period = 0; err_hold = 0; err_blink = 0;
    n_hs_low = 0; n_vs_low = 0; n_fs = 0; n_white = 0; white_col = -1;
    k = 0;
    #12 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_hsync", hsync, 1'b1);
    check_eq("rst_vsync", vsync, 1'b1);
    check_eq("rst_rgb", rgb, 12'h000);
    check_eq("rst_h_cnt", h_cnt, 10'd0);
    check_eq("rst_v_cnt", v_cnt, 10'd0);
    check_eq("rst_pix_en", pix_en, 1'b0);
    check_eq("rst_frame_start", frame_start, 1'b0);
    check_eq("rst_blink_phase", blink_phase, 1'b0);

    release_reset();

    // Priority: layers 1 and 2 valid, layer 1 wins
    run_until(kt(0, 5, 0));
    check_eq("prio_active", rgb, 12'hF00);
    run_until(151);
    check_eq("hwrap_last_h", last_h, 10'd151);
    check_eq("hwrap_last_v", last_v, 10'd0);
    run_until(152);
    check_eq("hwrap_h0", last_h, 10'd0);
    check_eq("hwrap_v1", last_v, 10'd1);
    run_until(kt(0, HA - 1, 1));
    check_eq("prio_last_active", rgb, 12'hF00);
    run_until(kt(0, HA, 1));
    check_eq("prio_blanking", rgb, 12'h000);
    run_until(kt(0, HT - 1, 1));

    mode = M_NONE;
    run_until(kt(0, 7, 2));
    check_eq("no_layer_bg", rgb, 12'h68A);
    run_until(kt(0, HA + HF - 1, 2));
    check_eq("hs_before_pulse", hsync, 1'b1);
    n_hs_low = 0;
    run_until(kt(0, HA + HF, 2));
    check_eq("hs_first_low", hsync, 1'b0);
    check_eq("hs_first_low_hcnt", last_h, 10'd130);
    run_until(kt(0, HT - 1, 2));
    check_eq("hs_low_ticks", n_hs_low, 16);

    mode = M_ALIGN;
    n_white = 0;
    run_until(kt(0, HT - 1, 5));
    check_eq("align_white_count", n_white, 3);
    check_eq("align_white_col", white_col, 100);

    mode = M_PRIO;
    run_until(kt(0, HT - 1, VT - 1));
    check_eq("vs_low_ticks", n_vs_low, 304);
    check_eq("frame_start_count", n_fs, 2);

    mode = M_BLINK;
    run_until(kt(1, 10, 2));
    check_eq("blink_f1_rgb", rgb, 12'h00F);
    check_eq("blink_f1_phase", blink_phase, 1'b0);
    run_until(2 * FT - 1);
    check_eq("blink_pre_toggle", blink_phase, 1'b0);
    run_until(2 * FT);
    check_eq("blink_toggle_f2", blink_phase, 1'b1);
    run_until(kt(2, 10, 2));
    check_eq("blink_f2_rgb", rgb, 12'hF00);
    run_until(kt(3, 10, 2));
    check_eq("blink_f3_rgb", rgb, 12'hF00);

    // Asynchronous reset in the middle of a frame
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("midrst_rgb", rgb, 12'h000);
    check_eq("midrst_h_cnt", h_cnt, 10'd0);
    check_eq("midrst_v_cnt", v_cnt, 10'd0);
    check_eq("midrst_blink_phase", blink_phase, 1'b0);
    check_eq("midrst_pix_en", pix_en, 1'b0);
    repeat (3) @(negedge clk);
    mode = M_PRIO;
    release_reset();
    run_until(0);
    check_eq("restart_h", last_h, 10'd0);
    check_eq("restart_v", last_v, 10'd0);
    check_eq("restart_frame_start", last_fs, 1'b1);
    run_until(kt(0, 5, 0));
    check_eq("restart_prio_rgb", rgb, 12'hF00);
    check_eq("restart_blink_phase", blink_phase, 1'b0);

    check_eq("stream_rgb_errors", err_rgb, 0);
    check_eq("stream_sync_errors", err_sync, 0);
    check_eq("stream_coord_errors", err_coord, 0);
    check_eq("stream_frame_start_errors", err_fs, 0);
    check_eq("stream_pix_en_period_errors", err_period, 0);
    check_eq("stream_hold_errors", err_hold, 0);
    check_eq("stream_blink_phase_errors", err_blink, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
